game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The module SHALL have parameter WIN_SCORE, default 11, points needed to win a game (legal range 1..15).
REQ-002 The module SHALL have parameter SERVE_DELAY, default 50, frame_tick pulses waited before each serve (legal range 1..255).
REQ-003 The module SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have port key_start  input  1  start button level, already synchronous to clk.
REQ-006 The module SHALL have port frame_tick  input  1  one-cycle pulse per display frame.
REQ-007 The module SHALL have port miss_l  input  1  one-cycle pulse: ball passed the left paddle, so right scores.
REQ-008 The module SHALL have port miss_r  input  1  one-cycle pulse: ball passed the right paddle, so left scores.
REQ-009 The module SHALL have port start  output  1  one-cycle pulse to the paddle and ball FSMs to begin a rally.
REQ-010 The module SHALL have port Break  output  1  level: rally halted, and paddle/ball FSMs hold.
REQ-011 The module SHALL have port serve_side  output  1  0 = left serves, 1 = right serves.
REQ-012 The module SHALL have port score_l  output  4  left player score.
REQ-013 The module SHALL have port score_r  output  4  right player score.
REQ-014 The module SHALL have port winner  output  2  00 none, 01 left, 10 right; 11 is never driven.
REQ-015 The module SHALL have port state_dbg  output  3  current state encoding.

Function
REQ-016 The states SHALL be IDLE=0, SERVE_WAIT=1, SERVE=2, RALLY=3, POINT=4 and GAME_OVER=5, and state_dbg SHALL equal the current state.
REQ-017 key_start edge SHALL mean key_start=1 with its previous-cycle registered value 0; a key held through reset SHALL NOT produce an edge.
REQ-018 In IDLE: Break=1; a key_start edge SHALL clear score_l, score_r and winner, clear the delay counter, and move to SERVE_WAIT.
REQ-019 In SERVE_WAIT: Break=1; each frame_tick SHALL increment the delay counter; the tick that brings the count to SERVE_DELAY SHALL move the FSM to SERVE on the next cycle.
REQ-020 The delay counter SHALL be 8 bits wide and SHALL clear on every entry to SERVE_WAIT.
REQ-021 SERVE SHALL last exactly one cycle, with start=1 and Break=0, then move to RALLY.
REQ-022 start SHALL be 1 only in SERVE.
REQ-023 In RALLY: Break=0; frame_tick SHALL be ignored.
REQ-024 In RALLY, miss_l alone SHALL increment score_r, set serve_side=0 and move to POINT.
REQ-025 In RALLY, miss_r alone SHALL increment score_l, set serve_side=1 and move to POINT.
REQ-026 In RALLY, miss_l and miss_r in the same cycle SHALL change neither score nor serve_side and SHALL move to POINT (point replayed).
REQ-027 miss_l and miss_r SHALL be ignored in every state except RALLY.
REQ-028 POINT SHALL last one cycle with Break=1.
REQ-029 From POINT: if score_l==WIN_SCORE, set winner=01 and go to GAME_OVER; else if score_r==WIN_SCORE, set winner=10 and go to GAME_OVER; else go to SERVE_WAIT.
REQ-030 Scores SHALL never exceed WIN_SCORE, and no increment SHALL occur once either score equals WIN_SCORE.
REQ-031 In GAME_OVER: Break=1 and winner is held; a key_start edge SHALL clear the scores and winner, invert serve_side, and move to SERVE_WAIT.
REQ-032 Undefined state encodings 6 and 7 SHALL return to IDLE on the next cycle, with Break=1.
REQ-033 All outputs SHALL be registered or decoded purely from registered state, with no combinational path from any input to any output.

Reset
REQ-034 While rst_n=0: state=IDLE, start=0, Break=1, serve_side=0, score_l=0, score_r=0, winner=00, delay counter=0, key edge register=0.
REQ-035 Reset SHALL take effect immediately and asynchronously, including mid-rally, with no start pulse emitted; the FSM SHALL leave IDLE only on a key_start edge after reset is released.

Verification (bench uses WIN_SCORE=3, SERVE_DELAY=2)
REQ-036 Reset then key_start edge -> SERVE_WAIT; after 2 frame_tick pulses, exactly one start pulse and Break falls to 0 in the same cycle as start.
REQ-037 In RALLY, pulse miss_r -> score_l=1, serve_side=1, one POINT cycle with Break=1, then SERVE_WAIT, then start after 2 more ticks.
REQ-038 Simultaneous miss_l and miss_r in RALLY -> scores unchanged at 1/0 and serve_side unchanged; miss pulses during SERVE_WAIT have no effect.
REQ-039 Drive score_r to 3 -> winner=10, state_dbg=5, Break=1; further miss pulses leave the scores unchanged; a key_start edge -> scores 0, winner 00, serve_side inverted.
REQ-040 Assert rst_n=0 in RALLY with score_l=2 -> all outputs immediately at reset values; key_start held high through reset release -> FSM stays in IDLE.
REQ-041 Hold key_start high for 10 cycles in IDLE -> only one transition to SERVE_WAIT.

Source files
------------

// File: rtl/game_ctrl.sv
// ============================================================================
// game_ctrl : match controller for a two-player paddle game (serve delay,
//             rally start/stop, scoring and winner detection).
// Rev 1.0
// ============================================================================
`default_nettype none

module game_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_DELAY = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       frame_tick,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       start,
    output logic       Break,
    output logic       serve_side,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        SERVE      = 3'd2,
        RALLY      = 3'd3,
        POINT      = 3'd4,
        GAME_OVER  = 3'd5
    } state_t;

    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [7:0] DELAY_VAL = 8'(SERVE_DELAY);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic       side_q, side_d;
    logic       key_q;
    logic       arm_q;
    logic       key_edge;
    logic       score_full;
    logic [7:0] cnt_inc;

    // arm_q stays low until key_start has been seen low after reset, so a
    // button held through reset release cannot start a game.
    assign key_edge   = key_start & ~key_q & arm_q;
    assign score_full = (score_l_q == WIN_VAL) || (score_r_q == WIN_VAL);
    assign cnt_inc    = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            winner_q  <= 2'b00;
            side_q    <= 1'b0;
            key_q     <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
            side_q    <= side_d;
            key_q     <= key_start;
            arm_q     <= arm_q | ~key_start;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        side_d    = side_q;
        case (state_q)
            IDLE: begin
                if (key_edge) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    winner_d  = 2'b00;
                    cnt_d     = 8'd0;
                    state_d   = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                if (frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DELAY_VAL) begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                state_d = RALLY;
            end
            RALLY: begin
                if (miss_l && !miss_r) begin
                    if (!score_full) begin
                        score_r_d = score_r_q + 4'd1;
                    end
                    side_d  = 1'b0;
                    state_d = POINT;
                end else if (miss_r && !miss_l) begin
                    if (!score_full) begin
                        score_l_d = score_l_q + 4'd1;
                    end
                    side_d  = 1'b1;
                    state_d = POINT;
                end else if (miss_l && miss_r) begin
                    state_d = POINT;
                end
            end
            POINT: begin
                if (score_l_q == WIN_VAL) begin
                    winner_d = 2'b01;
                    state_d  = GAME_OVER;
                end else if (score_r_q == WIN_VAL) begin
                    winner_d = 2'b10;
                    state_d  = GAME_OVER;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = SERVE_WAIT;
                end
            end
            GAME_OVER: begin
                if (key_edge) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    winner_d  = 2'b00;
                    side_d    = ~side_q;
                    cnt_d     = 8'd0;
                    state_d   = SERVE_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come only from registers; undefined encodings decode as halted.
    assign start      = (state_q == SERVE);
    assign Break      = !((state_q == SERVE) || (state_q == RALLY));
    assign serve_side = side_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign winner     = winner_q;
    assign state_dbg  = state_q;

endmodule

`default_nettype wire
